// File: rtl/shift_register_seq.sv
// Sequencing controller for a WIDTH-stage serial shift register: accepts a parallel word,
// clears the chain, shifts the word in one bit per clock, then captures and checks the taps.
module shift_register_seq #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             c,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic             lsb_first,
   input  logic             abort,
   output logic             ready,
   output logic             busy,
   output logic             sr_clr,
   output logic             sr_en,
   output logic             sr_in,
   input  logic [WIDTH-1:0] q_par,
   output logic [WIDTH-1:0] dout,
   output logic             done,
   output logic             mismatch
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StClear   = 2'd1;
   localparam logic [1:0] StShift   = 2'd2;
   localparam logic [1:0] StCapture = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             lsb_first_q, lsb_first_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             done_q, done_d;
   logic             mismatch_q, mismatch_d;

   logic [WIDTH-1:0] word_rev;
   logic [WIDTH-1:0] expected;
   logic [CntW-1:0]  bit_idx;

   always_comb begin
      word_rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         word_rev[i] = word_q[WIDTH-1-i];
      end
   end

   // The first bit sent ends up in the farthest stage, so LSB-first arrives bit-reversed.
   assign expected = lsb_first_q ? word_rev : word_q;
   assign bit_idx  = lsb_first_q ? cnt_q : (CntLast - cnt_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      lsb_first_d = lsb_first_q;
      dout_d      = dout_q;
      done_d      = 1'b0;
      mismatch_d  = mismatch_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StClear;
               word_d      = din;
               lsb_first_d = lsb_first;
            end
         end
         StClear: begin
            cnt_d = '0;
            if (abort) begin
               state_d = StIdle;
            end else begin
               state_d = StShift;
            end
         end
         StShift: begin
            if (abort) begin
               state_d = StIdle;
            end else if (cnt_q == CntLast) begin
               state_d = StCapture;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StCapture: begin
            state_d = StIdle;
            // Abort wins: leave the previous result untouched and skip the done pulse.
            if (!abort) begin
               dout_d     = q_par;
               done_d     = 1'b1;
               mismatch_d = (q_par != expected);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         word_q      <= '0;
         lsb_first_q <= 1'b0;
         dout_q      <= '0;
         done_q      <= 1'b0;
         mismatch_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         lsb_first_q <= lsb_first_d;
         dout_q      <= dout_d;
         done_q      <= done_d;
         mismatch_q  <= mismatch_d;
      end
   end

   assign ready    = (state_q == StIdle);
   assign busy     = (state_q != StIdle);
   assign sr_clr   = (state_q == StClear);
   assign sr_en    = (state_q == StShift);
   assign sr_in    = (state_q == StShift) & word_q[bit_idx];
   assign dout     = dout_q;
   assign done     = done_q;
   assign mismatch = mismatch_q;

endmodule

// File: tb/tb_shift_register_seq.sv
// Randomized bench for shift_register_seq with an ideal shift register attached and a
// transfer-level reference model computed from the bit order rules.
module tb_shift_register_seq;

   localparam int unsigned W = 4;

   logic         c = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] din;
   logic         lsb_first;
   logic         abort;
   logic         ready;
   logic         busy;
   logic         sr_clr;
   logic         sr_en;
   logic         sr_in;
   logic [W-1:0] q_par;
   logic [W-1:0] dout;
   logic         done;
   logic         mismatch;

   int n_cmp = 0;
   int n_err = 0;

   logic         fault = 1'b0;
   logic [W-1:0] sr_q = '0;
   logic [W-1:0] last_dout = '0;
   logic         last_mm = 1'b0;

   shift_register_seq #(.WIDTH(W)) dut (
      .c         (c),
      .rst       (rst),
      .start     (start),
      .din       (din),
      .lsb_first (lsb_first),
      .abort     (abort),
      .ready     (ready),
      .busy      (busy),
      .sr_clr    (sr_clr),
      .sr_en     (sr_en),
      .sr_in     (sr_in),
      .q_par     (q_par),
      .dout      (dout),
      .done      (done),
      .mismatch  (mismatch)
   );

   always #5 c = ~c;

   // Ideal external shift register; stage 0 takes sr_in, fault forces stage 0 stuck-at-0.
   always @(posedge c) begin
      if (sr_clr) sr_q <= '0;
      else if (sr_en) sr_q <= {sr_q[W-2:0], sr_in};
   end
   assign q_par = fault ? (sr_q & ~W'(1)) : sr_q;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge c);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_ready"}, ready, 1);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_sr_clr"}, sr_clr, 0);
      check_eq({tag, "_sr_en"}, sr_en, 0);
      check_eq({tag, "_sr_in"}, sr_in, 0);
   endtask

   // One transfer from accept edge to done (or abort). Called at posedge+1 with DUT idle.
   task automatic run_xfer(input logic [W-1:0] d, input logic lsb, input logic flt,
                           input int abort_at, input logic glitch);
      logic [W-1:0] got_word;
      logic [W-1:0] pattern;
      logic         bit_exp;
      int           j;
      fault = flt;
      check_eq("accept_ready", ready, 1);
      start     = 1'b1;
      din       = d;
      lsb_first = lsb;
      abort     = 1'($urandom_range(0, 1));
      step();
      start     = 1'b0;
      abort     = 1'b0;
      din       = W'($urandom);
      lsb_first = 1'($urandom);
      got_word  = '0;
      for (int k = 1; k <= W + 2; k++) begin
         if (k == 1) begin
            check_eq("t1_sr_clr", sr_clr, 1);
            check_eq("t1_ready", ready, 0);
            check_eq("t1_busy", busy, 1);
            check_eq("t1_sr_en", sr_en, 0);
            check_eq("t1_sr_in", sr_in, 0);
            check_eq("t1_done", done, 0);
         end else if (k <= W + 1) begin
            j = k - 2;
            bit_exp = lsb ? d[j] : d[W-1-j];
            // First bit sent travels to the farthest stage.
            got_word[W-1-j] = bit_exp;
            check_eq("shift_sr_en", sr_en, 1);
            check_eq("shift_sr_clr", sr_clr, 0);
            check_eq("shift_sr_in", sr_in, bit_exp);
         end else begin
            check_eq("cap_sr_en", sr_en, 0);
            check_eq("cap_sr_in", sr_in, 0);
            check_eq("cap_busy", busy, 1);
            check_eq("cap_done", done, 0);
         end
         if (glitch && k == 3) begin
            start     = 1'b1;
            din       = W'($urandom);
            lsb_first = 1'($urandom);
         end
         if (k == abort_at) abort = 1'b1;
         step();
         start = 1'b0;
         if (k == abort_at) begin
            abort = 1'b0;
            check_eq("abort_ready", ready, 1);
            check_eq("abort_sr_en", sr_en, 0);
            check_eq("abort_done", done, 0);
            check_eq("abort_dout", dout, last_dout);
            check_eq("abort_mismatch", mismatch, last_mm);
            return;
         end
      end
      for (int i = 0; i < W; i++) pattern[i] = lsb ? d[W-1-i] : d[i];
      if (flt) got_word[0] = 1'b0;
      check_eq("done_pulse", done, 1);
      check_eq("done_ready", ready, 1);
      check_eq("done_dout", dout, got_word);
      check_eq("done_mismatch", mismatch, got_word != pattern);
      last_dout = got_word;
      last_mm   = (got_word != pattern);
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         abort = 1'($urandom_range(0, 1));
         step();
         abort = 1'b0;
         check_eq("gap_done", done, 0);
         check_eq("gap_ready", ready, 1);
         check_eq("gap_dout", dout, last_dout);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      din       = '0;
      lsb_first = 1'b0;
      abort     = 1'b0;
      repeat (3) step();
      check_idle_outputs("rst");
      check_eq("rst_done", done, 0);
      check_eq("rst_mismatch", mismatch, 0);
      check_eq("rst_dout", dout, 0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         check_idle_outputs("quiet");
         check_eq("quiet_done", done, 0);
         check_eq("quiet_dout", dout, 0);
      end

      // Directed: MSB-first, LSB-first, stuck-at fault, abort in T3, start during SHIFT.
      run_xfer(4'b1011, 1'b0, 1'b0, 0, 1'b0);
      check_eq("msb_dout", dout, 4'b1011);
      idle_gap(1);
      run_xfer(4'b1011, 1'b1, 1'b0, 0, 1'b0);
      check_eq("lsb_dout", dout, 4'b1101);
      idle_gap(2);
      run_xfer(4'b0001, 1'b0, 1'b1, 0, 1'b0);
      check_eq("fault_mismatch", mismatch, 1);
      idle_gap(1);
      run_xfer(4'b0110, 1'b0, 1'b0, 3, 1'b0);
      idle_gap(1);
      run_xfer(4'b1001, 1'b1, 1'b0, 0, 1'b1);
      // Back-to-back: start issued in the done cycle.
      run_xfer(4'b0101, 1'b0, 1'b0, 0, 1'b0);
      run_xfer(4'b1110, 1'b1, 1'b0, 0, 1'b0);

      // Mid-SHIFT reset drops sr_en without waiting for a clock edge.
      fault     = 1'b0;
      start     = 1'b1;
      din       = 4'b1111;
      lsb_first = 1'b0;
      step();
      start = 1'b0;
      repeat (2) step();
      check_eq("pre_rst_sr_en", sr_en, 1);
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      check_eq("midrst_done", done, 0);
      check_eq("midrst_dout", dout, 0);
      check_eq("midrst_mismatch", mismatch, 0);
      step();
      rst       = 1'b0;
      last_dout = '0;
      last_mm   = 1'b0;
      idle_gap(2);

      for (int n = 0; n < 60; n++) begin
         logic [W-1:0] d;
         logic         lsb;
         logic         flt;
         int           ab;
         logic         gl;
         d   = W'($urandom);
         lsb = 1'($urandom);
         flt = ($urandom_range(0, 5) == 0);
         ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W + 2)) : 0;
         gl  = ($urandom_range(0, 3) == 0);
         run_xfer(d, lsb, flt, ab, gl);
         idle_gap(int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_register_seq.md
# shift_register_seq

Sequencing controller for the serial shift-register datapath. It accepts a parallel word through a valid/ready handshake, clears the external shift register, and shifts the word in serially, one bit per clock, with a shift enable. It then captures the register's parallel taps, compares them against the expected pattern, and reports completion. The block sits between a parallel-word producer and the `WIDTH`-stage serial shift-register chain.

## Interface
- `WIDTH`, default 4: number of shift-register stages and data-word width; legal range ≥ 2.
- `c` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: request to transfer `din`; accepted only when `ready`=1.
- `din` input `WIDTH`: parallel word, sampled on the accept edge.
- `lsb_first` input 1: bit order, sampled on the accept edge. 1 = `din[0]` is sent first; 0 = `din[WIDTH-1]` is sent first.
- `abort` input 1: cancels a transfer in progress.
- `ready` output 1: controller is idle and can accept `start`.
- `busy` output 1: transfer in progress (inverse of `ready`).
- `sr_clr` output 1: synchronous clear to the shift register.
- `sr_en` output 1: shift enable to the shift register.
- `sr_in` output 1: serial data bit to shift-register stage 0.
- `q_par` input `WIDTH`: parallel taps from the shift register; `q_par[WIDTH-1]` is the stage farthest from the input.
- `dout` output `WIDTH`: captured `q_par`, held until the next capture.
- `done` output 1: one-cycle completion pulse.
- `mismatch` output 1: valid while `done`=1; set if the captured value differs from the expected value.

## Operation
- States:
  - IDLE: `ready`=1.
  - CLEAR: `sr_clr`=1 for 1 cycle.
  - SHIFT: `sr_en`=1 for exactly `WIDTH` cycles.
  - CAPTURE: 1 cycle.
- Transitions:
  - IDLE → CLEAR on `start`&`ready`. On that edge, latch `din` into `word` and latch `lsb_first`.
  - CLEAR → SHIFT unconditionally.
  - SHIFT → CAPTURE when bit counter = `WIDTH`-1; otherwise increment the counter.
  - CAPTURE → IDLE unconditionally. On that edge, `dout` ← `q_par`, `done` ← 1, `mismatch` ← (`q_par` ≠ expected).
- Bit counter: width $clog2(`WIDTH`). Cleared in CLEAR, counts 0..`WIDTH`-1 in SHIFT, never wraps mid-transfer.
- `sr_in` during SHIFT with counter value i:
  - `lsb_first`=0: `word[WIDTH-1-i]`.
  - `lsb_first`=1: `word[i]`.
  - `sr_in`=0 in all other states.
- Expected value:
  - `lsb_first`=0: expected = `word`.
  - `lsb_first`=1: expected = bit-reverse of `word`.
- `sr_clr`, `sr_en`, `sr_in`, `ready`, `busy` are decoded only from state, counter and latched registers. There is no combinational path from any input port to any output.
- `start` outside IDLE is ignored, with no queuing.
- `abort` in CLEAR, SHIFT or CAPTURE:
  - Next edge goes to IDLE.
  - No `done`; `dout` and `mismatch` unchanged.
  - `abort` in IDLE has no effect.
  - `abort` takes priority over the CAPTURE capture.
- `start` and `abort` high together in IDLE: the start is accepted.
- Asserting `rst` at any time, including mid-SHIFT, immediately forces the reset state. Values in reset:
  - state = IDLE
  - `ready`=1, `busy`=0
  - `sr_clr`=0, `sr_en`=0, `sr_in`=0
  - `done`=0, `mismatch`=0
  - `dout`=0, counter = 0, `word`=0

## Timing
- Accept edge = edge where `start`=1 and `ready`=1; call the cycle after it T1.
- T1: `sr_clr`=1, `ready`=0.
- T2..T(`WIDTH`+1): `sr_en`=1, one bit per cycle. The shift register samples `sr_in` on each of these rising edges.
- T(`WIDTH`+2): CAPTURE; `q_par` is sampled at the end of this cycle.
- T(`WIDTH`+3): `done`=1, `dout`/`mismatch` valid, `ready`=1.
- Latency from accept edge to `done` = `WIDTH`+3 cycles (7 for `WIDTH`=4).
- A new `start` may be accepted in the `done` cycle. Back-to-back throughput is one word per `WIDTH`+3 cycles.
- `done` is exactly 1 cycle wide. `mismatch` is meaningful only with `done`.

## Test plan
- Reset check: hold `rst`=1 → `ready`=1, all other outputs 0. Release `rst`, hold `start`=0 for 20 cycles → no output change.
- MSB-first transfer, `WIDTH`=4, `din`=4'b1011, `lsb_first`=0, ideal shift-register model attached:
  - `sr_in` sequence in T2..T5 = 1,0,1,1.
  - `done` in T7, `dout`=4'b1011, `mismatch`=0.
- LSB-first transfer, `din`=4'b1011, `lsb_first`=1:
  - `sr_in` sequence = 1,1,0,1.
  - `dout`=4'b1101, `mismatch`=0.
- Fault injection: force `q_par[0]` stuck-at-0 with `din`=4'b0001, MSB-first → `done` with `dout`=4'b0000, `mismatch`=1.
- Abort and ignored start:
  - Assert `abort` in T3 → IDLE in the next cycle, no `done` pulse, `dout` unchanged.
  - `start` pulsed during SHIFT → ignored.
- Back-to-back and mid-transfer reset:
  - Assert `start` in the `done` cycle → second transfer starts with `sr_clr` the next cycle.
  - Assert `rst` mid-SHIFT → `sr_en` drops asynchronously and state returns to IDLE.
